// File: rtl/rr_arbiter4_2_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_2_if
// Brief    : Request/grant bundle between four requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter4_2_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    // Requesters drive req and observe the grant.
    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // The arbiter consumes req and drives the grant.
    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_2
// Brief    : Four-way round-robin arbiter with registered one-hot and encoded
//            grant, plus a hold timeout that forces release of the owner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4_2 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_arbiter4_2_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       r_gnt_idx;
    logic [1:0]       w_gnt_idx_nxt;
    logic             r_gnt_valid;
    logic             w_gnt_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic             w_pick_found;
    logic [1:0]       w_pick_idx;
    logic [1:0]       w_cand;

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = 2'd0;
        w_cand       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_pick_found && bus.req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            S_GRANT: begin
                // A voluntary drop wins over the timeout when both coincide.
                if (!bus.req[r_gnt_idx] || (r_cnt == c_max_hold)) begin
                    w_timeout_nxt   = bus.req[r_gnt_idx];
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_idx_nxt   = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 2'd1;
                    w_state_nxt     = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                // IDLE and the RELEASE bubble both arbitrate with the current pointer.
                if (w_pick_found) begin
                    w_gnt_nxt       = 4'b0001 << w_pick_idx;
                    w_gnt_idx_nxt   = w_pick_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_cnt_nxt       = c_cnt_one;
                    w_state_nxt     = S_GRANT;
                end else begin
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_idx_nxt   = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= '0;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire
